cia_sp_peer: RTL and testbench
==============================

# cia_sp_peer

- Serial-port partner for the CIA's SP/CNT pins; it is the far end of the CIA shift register in both directions.
- **Transmit:** shifts bytes into a CIA running in serial-input mode (CRA bit 6 = 0). It drives CNT as the clock master, MSB first.
- **Receive:** captures bytes shifted out by a CIA in serial-output mode (CRA bit 6 = 1).
- Sits beside the CIA in the C64 core and models a fast-serial peripheral (e.g. a drive or link cable).

## Interface
Parameters:
- HALF, default 4 — `ce` ticks per CNT half-period on transmit; legal range 2..255.

Ports:
- clk  in  1  system clock
- res  in  1  synchronous reset, active-high
- ce  in  1  Phi2-rate enable (connect `phi2_p`); all state advances only on `clk` edges with `ce`=1
- tx_data  in  8  byte to send
- tx_valid  in  1  byte offered
- tx_ready  out  1  block idle; a byte is accepted when `tx_valid & tx_ready & ce`
- rx_data  out  8  last received byte
- rx_valid  out  1  one-`clk` pulse when `rx_data` updates
- cnt_in  in  1  CNT as driven by the CIA (`cnt_out`)
- sp_in  in  1  SP as driven by the CIA (`sp_out`)
- cnt_out  out  1  CNT driven toward the CIA (`cnt_in`)
- sp_out  out  1  SP driven toward the CIA (`sp_in`)
- busy  out  1  transmit in progress (= `!tx_ready`)

## Operation
Reset (`res`=1 on a `clk` edge):
- `cnt_out`=1, `sp_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00.
- Bit counters and half-period counter cleared.
- Transmitter state IDLE; receiver edge history set to 1.

Transmit state machine:
- States: IDLE, SETUP, LOW.
- **IDLE:** `cnt_out`=1, `sp_out`=1. On accept, latch `tx_data` into an 8-bit shift register, set bit index 0, go to SETUP.
- **SETUP:** `cnt_out`=1, `sp_out`=shreg[7], held HALF ticks. Then go to LOW.
- **LOW:** `cnt_out`=0 and `sp_out` unchanged, held HALF ticks. The CIA samples SP on this falling edge. Then:
  - shift shreg left and increment the index;
  - if index was 7, go to IDLE (`cnt_out`=1 and `sp_out`=1 on the same edge);
  - otherwise go to SETUP.
- A new `tx_valid` is ignored while busy.
- `res` mid-byte aborts immediately. The partial byte is lost; the CIA bit counter is not resynchronised by this block.

Receiver:
- Register `cnt_in` on each `ce`.
- Rising edge (prev=0, now=1) with transmitter in IDLE: shift `sp_in` into rx shreg MSB first, increment the 3-bit rx index.
- On the 8th edge: `rx_data` = {shreg[6:0], sp_in}, pulse `rx_valid`, index wraps to 0.
- Edges of `cnt_in` while `busy`=1 are ignored. The shared open-collector CNT line echoes this block's own clock; these edges are never received as data.
- The receiver has no rate requirement. It follows any `cnt_in` waveform with half-periods of at least 1 `ce` tick.

## Timing
- Accept edge → `cnt_out` first falls: HALF ticks.
- Bit period: 2·HALF ticks. Byte: 16·HALF ticks from accept to `tx_ready`=1.
- A back-to-back next byte can be accepted on the edge `tx_ready` is seen high, giving 1 idle tick minimum between bytes.
- `sp_out` changes only on SETUP entry, at least HALF ticks before the falling CNT edge. Setup ≥ 2 ticks satisfies the CIA's 1-tick edge detection.
- Rx: `rx_valid` asserts on the `clk` edge where the 8th rising edge is detected, one `ce` tick after `cnt_in` rises. It lasts exactly one `clk`.
- Simultaneous accept and rx 8th edge: both complete on that edge. The rx byte is delivered because the edge is judged against pre-edge `busy`=0.

## Configuration
- **SP_PEER_RX_TIMEOUT_EN defined:** an 8-bit idle counter runs while rx index ≠ 0 and `cnt_in` is unchanged. After 255 ticks without an edge, the rx index clears and the partial byte is discarded with no `rx_valid`. The counter restarts on any `cnt_in` change.
- **Not defined:** the counter is absent and a partial byte waits indefinitely.

## Test plan
- Reset with `res`=1 for 3 clocks → `cnt_out`=1, `sp_out`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00.
- HALF=4; send 0xA5 → 8 falling `cnt_out` edges spaced 8 ticks. `sp_out` at each fall is 1,0,1,0,0,1,0,1. `tx_ready` returns 64 ticks after accept. A looped-back CIA in input mode reads SDR=0xA5 and sets ICR bit 3.
- CIA in output mode writes 0x3C with timer A = 2 → exactly one `rx_valid` with `rx_data`=0x3C.
- Loop `cnt_out`→`cnt_in` and `sp_out`→`sp_in`, send 0xFF → no `rx_valid` during or after the transfer.
- Assert `res` during bit 3 of a transmit → next edge `cnt_out`=1, `sp_out`=1, `tx_ready`=1. The next byte 0x81 transmits correctly.
- With SP_PEER_RX_TIMEOUT_EN: 3 rising `cnt_in` edges, stall 300 ticks, then 8 edges of 0x55 → single `rx_valid`, `rx_data`=0x55. Without the macro: `rx_valid` after the 5th edge of the second burst, with a corrupted value.

Source files
------------

// File: rtl/cia_sp_peer_if.sv
// Signal bundle between cia_sp_peer (slave side) and its host plus CIA SP/CNT pins (master side).
interface cia_sp_peer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cnt_in;
  logic       sp_in;
  logic       cnt_out;
  logic       sp_out;
  logic       busy;

  modport master (
    output tx_data, tx_valid, cnt_in, sp_in,
    input  tx_ready, rx_data, rx_valid, cnt_out, sp_out, busy
  );

  modport slave (
    input  tx_data, tx_valid, cnt_in, sp_in,
    output tx_ready, rx_data, rx_valid, cnt_out, sp_out, busy
  );
endinterface

// File: rtl/cia_sp_peer.sv
// Far-end partner of the CIA serial shift register: CNT-master transmitter and CNT-slave receiver.
// Optional build macro SP_PEER_RX_TIMEOUT_EN adds a receiver idle timeout that drops stalled partial bytes.
module cia_sp_peer #(
  parameter int unsigned HALF = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          ce,
  cia_sp_peer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_LOW   = 2'd2
  } state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF - 1);

  state_t     r_state, w_state_nx;
  logic [7:0] r_half_cnt, w_half_cnt_nx;
  logic [6:0] r_shreg, w_shreg_nx;
  logic [2:0] r_bit_idx, w_bit_idx_nx;
  logic       r_cnt_out, w_cnt_out_nx;
  logic       r_sp_out, w_sp_out_nx;
  logic       r_tx_ready, w_tx_ready_nx;
  logic       w_accept;
  logic       w_half_done;
  logic       w_busy;

  logic       r_cnt_prev;
  logic [6:0] r_rx_shreg;
  logic [2:0] r_rx_idx;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       w_rx_edge;
  logic       w_rx_timeout;

  assign w_busy      = ~r_tx_ready;
  assign w_accept    = bus.tx_valid & r_tx_ready & ce;
  assign w_half_done = (r_half_cnt == HALF_LAST);

  // Transmit next-state and output decode
  always_comb begin
    w_state_nx    = r_state;
    w_half_cnt_nx = r_half_cnt;
    w_shreg_nx    = r_shreg;
    w_bit_idx_nx  = r_bit_idx;
    w_cnt_out_nx  = r_cnt_out;
    w_sp_out_nx   = r_sp_out;
    w_tx_ready_nx = r_tx_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Bit 7 goes straight onto SP; the shift register keeps the remaining seven.
          w_state_nx    = S_SETUP;
          w_shreg_nx    = bus.tx_data[6:0];
          w_bit_idx_nx  = 3'd0;
          w_half_cnt_nx = 8'd0;
          w_cnt_out_nx  = 1'b1;
          w_sp_out_nx   = bus.tx_data[7];
          w_tx_ready_nx = 1'b0;
        end else begin
          w_cnt_out_nx  = 1'b1;
          w_sp_out_nx   = 1'b1;
          w_tx_ready_nx = 1'b1;
        end
      end
      S_SETUP: begin
        if (ce) begin
          if (w_half_done) begin
            w_state_nx    = S_LOW;
            w_half_cnt_nx = 8'd0;
            w_cnt_out_nx  = 1'b0;
          end else begin
            w_half_cnt_nx = r_half_cnt + 8'd1;
          end
        end else begin
          w_half_cnt_nx = r_half_cnt;
        end
      end
      S_LOW: begin
        if (ce) begin
          if (w_half_done) begin
            w_half_cnt_nx = 8'd0;
            w_shreg_nx    = {r_shreg[5:0], 1'b0};
            w_bit_idx_nx  = r_bit_idx + 3'd1;
            w_cnt_out_nx  = 1'b1;
            if (r_bit_idx == 3'd7) begin
              w_state_nx    = S_IDLE;
              w_sp_out_nx   = 1'b1;
              w_tx_ready_nx = 1'b1;
            end else begin
              w_state_nx    = S_SETUP;
              w_sp_out_nx   = r_shreg[6];
            end
          end else begin
            w_half_cnt_nx = r_half_cnt + 8'd1;
          end
        end else begin
          w_half_cnt_nx = r_half_cnt;
        end
      end
      default: begin
        w_state_nx    = S_IDLE;
        w_half_cnt_nx = 8'd0;
        w_cnt_out_nx  = 1'b1;
        w_sp_out_nx   = 1'b1;
        w_tx_ready_nx = 1'b1;
      end
    endcase
  end

  // Transmit state register
  always_ff @(posedge clk) begin
    if (res) begin
      r_state    <= S_IDLE;
      r_half_cnt <= 8'd0;
      r_shreg    <= 7'd0;
      r_bit_idx  <= 3'd0;
      r_cnt_out  <= 1'b1;
      r_sp_out   <= 1'b1;
      r_tx_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_half_cnt <= w_half_cnt_nx;
      r_shreg    <= w_shreg_nx;
      r_bit_idx  <= w_bit_idx_nx;
      r_cnt_out  <= w_cnt_out_nx;
      r_sp_out   <= w_sp_out_nx;
      r_tx_ready <= w_tx_ready_nx;
    end
  end

  // Edges are judged against pre-edge busy, so an accept on the 8th rx edge still delivers the byte.
  assign w_rx_edge = ce & ~r_cnt_prev & bus.cnt_in & ~w_busy;

`ifdef SP_PEER_RX_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       w_rx_stall;

  assign w_rx_stall   = (r_rx_idx != 3'd0) & (bus.cnt_in == r_cnt_prev);
  assign w_rx_timeout = ce & w_rx_stall & (r_idle_cnt == 8'd254);

  // Idle tick counter for a partially received byte
  always_ff @(posedge clk) begin
    if (res) begin
      r_idle_cnt <= 8'd0;
    end else if (ce) begin
      if (w_rx_stall & ~w_rx_timeout) begin
        r_idle_cnt <= r_idle_cnt + 8'd1;
      end else begin
        r_idle_cnt <= 8'd0;
      end
    end else begin
      r_idle_cnt <= r_idle_cnt;
    end
  end
`else
  assign w_rx_timeout = 1'b0;
`endif

  // Receiver shift register, byte delivery and CNT edge history
  always_ff @(posedge clk) begin
    if (res) begin
      r_cnt_prev <= 1'b1;
      r_rx_shreg <= 7'd0;
      r_rx_idx   <= 3'd0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (ce) begin
        // History is pinned high while transmitting so our own final CNT rise is not seen as data.
        r_cnt_prev <= w_busy ? 1'b1 : bus.cnt_in;
        if (w_rx_edge) begin
          r_rx_shreg <= {r_rx_shreg[5:0], bus.sp_in};
          r_rx_idx   <= r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) begin
            r_rx_data  <= {r_rx_shreg, bus.sp_in};
            r_rx_valid <= 1'b1;
          end else begin
            r_rx_data  <= r_rx_data;
          end
        end else if (w_rx_timeout) begin
          r_rx_idx <= 3'd0;
        end else begin
          r_rx_idx <= r_rx_idx;
        end
      end else begin
        r_cnt_prev <= r_cnt_prev;
      end
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.busy     = ~r_tx_ready;
  assign bus.cnt_out  = r_cnt_out;
  assign bus.sp_out   = r_sp_out;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_cia_sp_peer.sv
// Self-checking bench for cia_sp_peer: a CIA-like model samples SP on CNT falls and shifts bytes in on CNT rises.
module tb_cia_sp_peer;
  localparam int HALF = 4;

  typedef struct {
    bit         is_tx;
    logic [7:0] data;
    int         hp;
    logic [7:0] exp_data;
    int         exp_pulses;
  } vec_t;

  logic clk;
  logic res;
  logic ce;
  logic drv_cnt;
  logic drv_sp;
  logic loop_en;

  int         total;
  int         bad;
  int         tick_no;
  int         rx_cnt;
  int         rx_tick;
  int         falls;
  int         t0;
  int         t_done;
  int         last_rise;
  int         fall_tick[8];
  logic [7:0] rx_last;
  logic [7:0] cap;
  logic       prev_cnt_out;
  logic       prev_rx_valid;

  cia_sp_peer_if bus();

  assign bus.cnt_in = loop_en ? bus.cnt_out : drv_cnt;
  assign bus.sp_in  = loop_en ? bus.sp_out  : drv_sp;

  cia_sp_peer #(.HALF(HALF)) dut (
    .clk (clk),
    .res (res),
    .ce  (ce),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clk edge; the sample after it feeds the CIA-side model.
  task automatic clk_cycle(input logic ce_v);
    ce = ce_v;
    @(posedge clk);
    #1;
    if (ce_v) tick_no++;
    if (prev_rx_valid === 1'b1) check("rx_valid_one_clk", int'(bus.rx_valid), 0);
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      rx_last = bus.rx_data;
      rx_tick = tick_no;
    end
    check("busy_vs_ready", int'(bus.busy), int'(!bus.tx_ready));
    if (prev_cnt_out === 1'b1 && bus.cnt_out === 1'b0) begin
      if (falls < 8) fall_tick[falls] = tick_no;
      cap = {cap[6:0], bus.sp_out};
      falls++;
    end
    prev_cnt_out  = bus.cnt_out;
    prev_rx_valid = bus.rx_valid;
  endtask

  task automatic tick();
    clk_cycle(1'b0);
    clk_cycle(1'b1);
  endtask

  task automatic clear_tx_model();
    falls = 0;
    cap   = 8'h00;
    for (int k = 0; k < 8; k++) fall_tick[k] = -1000;
  endtask

  task automatic check_tx_shape(input logic [7:0] b, input string nm);
    bit spacing_ok;
    check({nm, "_falls"}, falls, 8);
    check({nm, "_data"}, int'(cap), int'(b));
    check({nm, "_first_fall"}, fall_tick[0] - t0, HALF);
    spacing_ok = 1'b1;
    for (int k = 1; k < 8; k++)
      if (fall_tick[k] - fall_tick[k-1] != 2 * HALF) spacing_ok = 1'b0;
    check({nm, "_fall_spacing"}, int'(spacing_ok), 1);
  endtask

  // Offer a byte, hold tx_valid with other data while busy, wait for completion.
  task automatic send_byte(input logic [7:0] b, input string nm);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check({nm, "_idle_before"}, int'(bus.tx_ready), 1);
    clear_tx_model();
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    tick();
    t0 = tick_no;
    check({nm, "_busy_after_accept"}, int'(bus.busy), 1);
    bus.tx_data = ~b;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 40 * HALF) begin
      if (n == 8 * HALF) bus.tx_valid = 1'b0;
      tick();
      n++;
    end
    bus.tx_valid = 1'b0;
    t_done = tick_no;
    check({nm, "_byte_ticks"}, t_done - t0, 16 * HALF);
    check({nm, "_idle_cnt"}, int'(bus.cnt_out), 1);
    check({nm, "_idle_sp"}, int'(bus.sp_out), 1);
    check_tx_shape(b, nm);
  endtask

  // Behave like a CIA in output mode: SP changes with CNT low, peer samples on the rise.
  task automatic cia_bits(input logic [7:0] b, input int nbits, input int hp);
    for (int i = 7; i > 7 - nbits; i--) begin
      drv_sp  = b[i];
      drv_cnt = 1'b0;
      repeat (hp) tick();
      drv_cnt   = 1'b1;
      last_rise = tick_no;
      repeat (hp) tick();
    end
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0] rb;
    int         rhp;
    int         n;
    int         td;
    total = 0; bad = 0; tick_no = 0; rx_cnt = 0; rx_tick = -1;
    last_rise = 0; rx_last = 8'h00; prev_cnt_out = 1'b1; prev_rx_valid = 1'b0;
    clear_tx_model();
    res = 1'b1; ce = 1'b0; drv_cnt = 1'b1; drv_sp = 1'b1; loop_en = 1'b0;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;

    vecs[0] = '{1'b1, 8'hA5, 0, 8'hA5, 0};
    vecs[1] = '{1'b1, 8'h00, 0, 8'h00, 0};
    vecs[2] = '{1'b1, 8'hFF, 0, 8'hFF, 0};
    vecs[3] = '{1'b1, 8'h81, 0, 8'h81, 0};
    vecs[4] = '{1'b0, 8'h3C, 3, 8'h3C, 1};
    vecs[5] = '{1'b0, 8'h00, 1, 8'h00, 1};
    vecs[6] = '{1'b0, 8'hFF, 2, 8'hFF, 1};
    vecs[7] = '{1'b0, 8'h5A, 7, 8'h5A, 1};
    vecs[8] = '{1'b0, 8'h96, 1, 8'h96, 1};

    repeat (3) clk_cycle(1'b1);
    check("reset_cnt_out", int'(bus.cnt_out), 1);
    check("reset_sp_out", int'(bus.sp_out), 1);
    check("reset_tx_ready", int'(bus.tx_ready), 1);
    check("reset_rx_valid", int'(bus.rx_valid), 0);
    check("reset_rx_data", int'(bus.rx_data), 0);
    res = 1'b0;
    repeat (3) tick();

    for (int v = 0; v < 9; v++) begin
      rx_cnt = 0;
      if (vecs[v].is_tx) begin
        send_byte(vecs[v].data, "tbl_tx");
        check("tbl_tx_cia_view", int'(cap), int'(vecs[v].exp_data));
        check("tbl_tx_no_rx", rx_cnt, vecs[v].exp_pulses);
      end else begin
        cia_bits(vecs[v].data, 8, vecs[v].hp);
        repeat (3) tick();
        check("tbl_rx_pulses", rx_cnt, vecs[v].exp_pulses);
        check("tbl_rx_data", int'(rx_last), int'(vecs[v].exp_data));
        check("tbl_rx_latency", rx_tick - last_rise, 1);
      end
    end

    for (int it = 0; it < 16; it++) begin
      rb  = 8'($urandom);
      rhp = int'($urandom_range(1, 6));
      rx_cnt = 0;
      if ($urandom_range(0, 1) == 1) begin
        send_byte(rb, "rnd_tx");
        check("rnd_tx_no_rx", rx_cnt, 0);
      end else begin
        cia_bits(rb, 8, rhp);
        repeat (2) tick();
        check("rnd_rx_pulses", rx_cnt, 1);
        check("rnd_rx_data", int'(rx_last), int'(rb));
      end
    end

    send_byte(8'h3C, "b2b_a");
    td = t_done;
    send_byte(8'hC3, "b2b_b");
    check("b2b_gap", t0 - td, 1);

    loop_en = 1'b1;
    rx_cnt  = 0;
    send_byte(8'hFF, "loop_ff");
    repeat (10) tick();
    check("loop_ff_no_rx", rx_cnt, 0);
    send_byte(8'h5A, "loop_5a");
    repeat (10) tick();
    check("loop_5a_no_rx", rx_cnt, 0);
    loop_en = 1'b0;
    repeat (2) tick();

    // Abort during bit 3, then a clean byte.
    clear_tx_model();
    bus.tx_data  = 8'h12;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (6 * HALF + HALF + 1) tick();
    check("abort_busy_before", int'(bus.busy), 1);
    res = 1'b1;
    clk_cycle(1'b0);
    res = 1'b0;
    check("abort_cnt_out", int'(bus.cnt_out), 1);
    check("abort_sp_out", int'(bus.sp_out), 1);
    check("abort_tx_ready", int'(bus.tx_ready), 1);
    tick();
    send_byte(8'h81, "after_abort");

    // Accept and 8th rx edge on the same ce edge.
    rx_cnt = 0;
    cia_bits(8'hC3, 7, 2);
    drv_sp  = 1'b1;
    drv_cnt = 1'b0;
    repeat (2) tick();
    check("simul_ready_pre", int'(bus.tx_ready), 1);
    clear_tx_model();
    drv_cnt      = 1'b1;
    bus.tx_data  = 8'h99;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    t0 = tick_no;
    check("simul_rx_pulses", rx_cnt, 1);
    check("simul_rx_data", int'(rx_last), 8'hC3);
    check("simul_rx_tick", rx_tick, tick_no);
    check("simul_tx_busy", int'(bus.busy), 1);
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 40 * HALF) begin
      tick();
      n++;
    end
    check("simul_tx_ticks", tick_no - t0, 16 * HALF);
    check_tx_shape(8'h99, "simul_tx");
    check("simul_rx_total", rx_cnt, 1);

    // Stalled partial byte followed by a full byte.
    rx_cnt = 0;
    cia_bits(8'hA0, 3, 2);
    repeat (300) tick();
    check("stall_no_rx", rx_cnt, 0);
    cia_bits(8'h55, 8, 2);
    repeat (3) tick();
    check("stall_pulses", rx_cnt, 1);
`ifdef SP_PEER_RX_TIMEOUT_EN
    check("stall_data", int'(rx_last), 8'h55);
`else
    check("stall_data", int'(rx_last), 8'hAA);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
